// File: rtl/sfu_acc_act_if.sv
// Psum stream bundle: input beats from the PE array, results to the output SRAM port.
// The slave side is the special-function unit; the master side is its environment.
interface sfu_acc_act_if #(
  parameter int psum_bw = 16,
  parameter int col     = 8
);
  logic                   in_valid;
  logic                   in_ready;
  logic [col*psum_bw-1:0] psum_in;
  logic                   out_valid;
  logic                   out_ready;
  logic [col*psum_bw-1:0] psum_out;

  modport master (
    output in_valid, psum_in, out_ready,
    input  in_ready, out_valid, psum_out
  );

  modport slave (
    input  in_valid, psum_in, out_ready,
    output in_ready, out_valid, psum_out
  );
endinterface

// File: rtl/sfu_acc_act.sv
// Special-function unit: per-lane group accumulation, selectable activation and
// saturation, with a single valid/ready output register and a raw bypass path.
module sfu_acc_act #(
  parameter int psum_bw = 16,
  parameter int col     = 8,
  parameter int cnt_bw  = 4,
  parameter int acc_bw  = psum_bw + cnt_bw
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [cnt_bw-1:0] cfg_acc_len,
  input  logic [1:0]        cfg_act_mode,
  input  logic [3:0]        cfg_lrelu_shift,
  input  logic              psum_bypass_i,
  sfu_acc_act_if.slave      bus,
  output logic              busy
);
  typedef enum logic {IDLE, ACC} state_t;

  state_t                 state_q, state_d;
  logic [cnt_bw-1:0]      cnt_q, cnt_d;
  logic [cnt_bw-1:0]      len_q, len_d;
  logic [1:0]             mode_q, mode_d;
  logic [3:0]             shift_q, shift_d;
  logic                   out_valid_q, out_valid_d;
  logic [col*psum_bw-1:0] psum_out_q, psum_out_d;
  logic [col*psum_bw-1:0] res_w;
  logic                   accept;
  logic                   acc_we;
  logic [cnt_bw-1:0]      eff_len;
  logic [1:0]             act_mode;
  logic [3:0]             act_shift;

  assign accept       = bus.in_valid & ~out_valid_q;
  assign bus.in_ready = ~out_valid_q;
  assign bus.out_valid = out_valid_q;
  assign bus.psum_out  = psum_out_q;
  assign busy          = (state_q == ACC);

  // A length-1 group finishes in IDLE, so activation must see the live config there.
  assign eff_len   = (cfg_acc_len == '0) ? {{(cnt_bw-1){1'b0}}, 1'b1} : cfg_acc_len;
  assign act_mode  = (state_q == IDLE) ? cfg_act_mode    : mode_q;
  assign act_shift = (state_q == IDLE) ? cfg_lrelu_shift : shift_q;

  generate
    for (genvar gi = 0; gi < col; gi++) begin : g_lane
      logic signed [acc_bw-1:0] acc_q;
      logic signed [acc_bw-1:0] sext;
      logic signed [acc_bw-1:0] acc_next;
      logic signed [acc_bw-1:0] act_v;
      logic        [psum_bw-1:0] sat_v;

      assign sext     = acc_bw'($signed(bus.psum_in[gi*psum_bw +: psum_bw]));
      assign acc_next = (state_q == IDLE) ? sext : acc_q + sext;

      always_comb begin
        act_v = acc_next;
        case (act_mode)
          2'd1:    if (acc_next < 0) act_v = '0;
          2'd2:    if (acc_next < 0) act_v = acc_next >>> act_shift;
          2'd3:    if (acc_next < 0) act_v = -acc_next;
          default: act_v = acc_next;
        endcase
      end

      always_comb begin
        if (act_v > $signed({{(acc_bw-psum_bw+1){1'b0}}, {(psum_bw-1){1'b1}}}))
          sat_v = {1'b0, {(psum_bw-1){1'b1}}};
        else if (act_v < $signed({{(acc_bw-psum_bw+1){1'b1}}, {(psum_bw-1){1'b0}}}))
          sat_v = {1'b1, {(psum_bw-1){1'b0}}};
        else
          sat_v = act_v[psum_bw-1:0];
      end

      always_ff @(posedge clk) begin
        if (reset)       acc_q <= '0;
        else if (acc_we) acc_q <= acc_next;
      end

      assign res_w[gi*psum_bw +: psum_bw] = sat_v;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      len_q       <= '0;
      mode_q      <= '0;
      shift_q     <= '0;
      out_valid_q <= 1'b0;
      psum_out_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      mode_q      <= mode_d;
      shift_q     <= shift_d;
      out_valid_q <= out_valid_d;
      psum_out_q  <= psum_out_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    mode_d      = mode_q;
    shift_d     = shift_q;
    acc_we      = 1'b0;
    out_valid_d = out_valid_q & ~bus.out_ready;
    psum_out_d  = psum_out_q;
    case (state_q)
      IDLE: begin
        if (accept && psum_bypass_i) begin
          psum_out_d  = bus.psum_in;
          out_valid_d = 1'b1;
        end else if (accept) begin
          len_d   = eff_len;
          mode_d  = cfg_act_mode;
          shift_d = cfg_lrelu_shift;
          acc_we  = 1'b1;
          cnt_d   = {{(cnt_bw-1){1'b0}}, 1'b1};
          if (eff_len == {{(cnt_bw-1){1'b0}}, 1'b1}) begin
            psum_out_d  = res_w;
            out_valid_d = 1'b1;
          end else begin
            state_d = ACC;
          end
        end
      end
      ACC: begin
        if (accept) begin
          acc_we = 1'b1;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q + 1'b1 == len_q) begin
            psum_out_d  = res_w;
            out_valid_d = 1'b1;
            state_d     = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_sfu_acc_act.sv
// Scoreboard bench for sfu_acc_act: expected result vectors are queued as groups
// are driven and popped when the unit presents out_valid.
module tb_sfu_acc_act;
  localparam int PSUM_BW = 16;
  localparam int COL     = 8;
  localparam int CNT_BW  = 4;
  localparam int W       = PSUM_BW * COL;

  logic              clk = 1'b0;
  logic              reset;
  logic [CNT_BW-1:0] cfg_acc_len;
  logic [1:0]        cfg_act_mode;
  logic [3:0]        cfg_lrelu_shift;
  logic              psum_bypass_i;
  logic              busy;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] ev, got, held;
  bit ok;

  sfu_acc_act_if #(.psum_bw(PSUM_BW), .col(COL)) bus ();

  sfu_acc_act #(.psum_bw(PSUM_BW), .col(COL), .cnt_bw(CNT_BW)) dut (
    .clk             (clk),
    .reset           (reset),
    .cfg_acc_len     (cfg_acc_len),
    .cfg_act_mode    (cfg_act_mode),
    .cfg_lrelu_shift (cfg_lrelu_shift),
    .psum_bypass_i   (psum_bypass_i),
    .bus             (bus),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] mk(input int l0, input int l1, input int l2);
    logic [W-1:0] v;
    v = '0;
    v[PSUM_BW-1:0]           = l0[PSUM_BW-1:0];
    v[2*PSUM_BW-1:PSUM_BW]   = l1[PSUM_BW-1:0];
    v[3*PSUM_BW-1:2*PSUM_BW] = l2[PSUM_BW-1:0];
    return v;
  endfunction

  function automatic int model(input int s, input int mode, input int sh);
    int a;
    case (mode)
      1:       a = (s < 0) ? 0 : s;
      2:       a = (s < 0) ? (s >>> sh) : s;
      3:       a = (s < 0) ? -s : s;
      default: a = s;
    endcase
    if (a > 32767)  a = 32767;
    if (a < -32768) a = -32768;
    return a;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [W-1:0] d);
    bus.in_valid = 1'b1;
    bus.psum_in  = d;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out(output bit found);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.out_valid === 1'b1) begin
        found = 1'b1;
        return;
      end
      tick();
    end
  endtask

  task automatic release_out();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", bus.out_valid); end
    checks++; if (bus.psum_out !== '0) begin errors++; $display("FAIL reset_psum_out got %h exp 0", bus.psum_out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", bus.in_ready); end
    $display("test_reset done");
  endtask

  task automatic test_relu_group();
    cfg_acc_len = 4'd3; cfg_act_mode = 2'd1; cfg_lrelu_shift = 4'd0;
    exp_q.push_back(mk(75, 0, 0));
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL relu_busy_pre got %b exp 0", busy); end
    beat(mk(100, -10, 0));
    cfg_act_mode = 2'd0; cfg_acc_len = 4'd1;  // must be ignored mid-group
    checks++; if (busy !== 1'b1 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL relu_beat1 got busy=%b ov=%b exp busy=1 ov=0", busy, bus.out_valid); end
    beat(mk(-30, -20, 0));
    checks++; if (busy !== 1'b1 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL relu_beat2 got busy=%b ov=%b exp busy=1 ov=0", busy, bus.out_valid); end
    beat(mk(5, 5, 0));
    checks++; if (busy !== 1'b0 || bus.out_valid !== 1'b1) begin errors++; $display("FAIL relu_latency got busy=%b ov=%b exp busy=0 ov=1", busy, bus.out_valid); end
    got = bus.psum_out; ev = exp_q.pop_front();
    checks++; if (got !== ev) begin errors++; $display("FAIL relu_result got %h exp %h", got, ev); end
    release_out();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL relu_release got ov=%b exp 0", bus.out_valid); end
    $display("test_relu_group result %h", got);
  endtask

  task automatic test_saturate();
    cfg_acc_len = 4'd4; cfg_act_mode = 2'd0;
    exp_q.push_back(mk(32767, -32768, 0));
    for (int i = 0; i < 4; i++) beat(mk(30000, -30000, 0));
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL sat_latency got ov=%b exp 1", bus.out_valid); end
    got = bus.psum_out; ev = exp_q.pop_front();
    checks++; if (got !== ev) begin errors++; $display("FAIL sat_result got %h exp %h", got, ev); end
    release_out();
    $display("test_saturate result %h", got);
  endtask

  task automatic test_lrelu_abs();
    cfg_acc_len = 4'd1; cfg_act_mode = 2'd2; cfg_lrelu_shift = 4'd2;
    exp_q.push_back(mk(-25, -1, 64));
    beat(mk(-100, -1, 64));
    checks++; if (bus.out_valid !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL lrelu_latency got ov=%b busy=%b exp ov=1 busy=0", bus.out_valid, busy); end
    got = bus.psum_out; ev = exp_q.pop_front();
    checks++; if (got !== ev) begin errors++; $display("FAIL lrelu_result got %h exp %h", got, ev); end
    release_out();
    cfg_act_mode = 2'd3;
    exp_q.push_back(mk(32767, 7, 0));
    beat(mk(-32768, -7, 0));
    got = bus.psum_out; ev = exp_q.pop_front();
    checks++; if (bus.out_valid !== 1'b1 || got !== ev) begin errors++; $display("FAIL abs_result got ov=%b %h exp ov=1 %h", bus.out_valid, got, ev); end
    release_out();
    $display("test_lrelu_abs result %h", got);
  endtask

  task automatic test_backpressure();
    cfg_acc_len = 4'd2; cfg_act_mode = 2'd0;
    exp_q.push_back(mk(11, 22, 0));
    beat(mk(10, 20, 0));
    beat(mk(1, 2, 0));
    cfg_acc_len = 4'd1;
    held = exp_q[0];
    bus.in_valid = 1'b1;
    bus.psum_in  = mk(999, -999, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.psum_out !== held) begin
        errors++;
        $display("FAIL bp_stall cyc %0d got ov=%b ir=%b %h exp ov=1 ir=0 %h", i, bus.out_valid, bus.in_ready, bus.psum_out, held);
      end
    end
    got = bus.psum_out; ev = exp_q.pop_front();
    checks++; if (got !== ev) begin errors++; $display("FAIL bp_result got %h exp %h", got, ev); end
    bus.out_ready = 1'b1;
    exp_q.push_back(mk(999, -999, 0));
    tick();
    bus.out_ready = 1'b0;
    checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_release got ov=%b ir=%b exp ov=0 ir=1", bus.out_valid, bus.in_ready); end
    tick();
    bus.in_valid = 1'b0;
    got = bus.psum_out; ev = exp_q.pop_front();
    checks++; if (bus.out_valid !== 1'b1 || got !== ev) begin errors++; $display("FAIL bp_next_beat got ov=%b %h exp ov=1 %h", bus.out_valid, got, ev); end
    release_out();
    $display("test_backpressure result %h", got);
  endtask

  task automatic test_bypass();
    psum_bypass_i = 1'b1; cfg_acc_len = 4'd3; cfg_act_mode = 2'd1;
    exp_q.push_back(mk(-5, -300, 40));
    beat(mk(-5, -300, 40));
    psum_bypass_i = 1'b0;
    checks++; if (bus.out_valid !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL bypass_latency got ov=%b busy=%b exp ov=1 busy=0", bus.out_valid, busy); end
    got = bus.psum_out; ev = exp_q.pop_front();
    checks++; if (got !== ev) begin errors++; $display("FAIL bypass_result got %h exp %h", got, ev); end
    release_out();
    $display("test_bypass result %h", got);
  endtask

  task automatic test_reset_mid();
    cfg_acc_len = 4'd4; cfg_act_mode = 2'd0;
    beat(mk(1000, 1000, 0));
    beat(mk(1000, 1000, 0));
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrst_busy got %b exp 1", busy); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.psum_out !== '0) begin errors++; $display("FAIL midrst_clear got busy=%b ov=%b %h exp 0 0 0", busy, bus.out_valid, bus.psum_out); end
    cfg_acc_len = 4'd1;
    exp_q.push_back(mk(7, 0, 0));
    beat(mk(7, 0, 0));
    got = bus.psum_out; ev = exp_q.pop_front();
    checks++; if (bus.out_valid !== 1'b1 || got !== ev) begin errors++; $display("FAIL midrst_new got ov=%b %h exp ov=1 %h", bus.out_valid, got, ev); end
    release_out();
    $display("test_reset_mid result %h", got);
  endtask

  task automatic test_random_groups();
    int lens[4] = '{0, 5, 2, 7};
    for (int g = 0; g < 4; g++) begin
      int len, mode, sh;
      int sums[COL];
      logic [W-1:0] v, e;
      len  = (lens[g] == 0) ? 1 : lens[g];
      mode = g;
      sh   = int'($urandom_range(0, 15));
      cfg_acc_len = lens[g][CNT_BW-1:0]; cfg_act_mode = mode[1:0]; cfg_lrelu_shift = sh[3:0];
      for (int k = 0; k < COL; k++) sums[k] = 0;
      for (int b = 0; b < len; b++) begin
        for (int k = 0; k < COL; k++) begin
          int x;
          x = int'($urandom_range(0, 65535)) - 32768;
          sums[k] += x;
          v[k*PSUM_BW +: PSUM_BW] = x[PSUM_BW-1:0];
        end
        beat(v);
      end
      for (int k = 0; k < COL; k++) begin
        int r;
        r = model(sums[k], mode, sh);
        e[k*PSUM_BW +: PSUM_BW] = r[PSUM_BW-1:0];
      end
      exp_q.push_back(e);
      wait_out(ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL rand_timeout group %0d got ov=%b exp ov=1", g, bus.out_valid);
        void'(exp_q.pop_front());
      end else begin
        got = bus.psum_out; ev = exp_q.pop_front();
        if (got !== ev) begin errors++; $display("FAIL rand_result group %0d len %0d mode %0d got %h exp %h", g, len, mode, got, ev); end
      end
      release_out();
      $display("test_random_groups group %0d len %0d mode %0d shift %0d result %h", g, len, mode, sh, got);
    end
  endtask

  initial begin
    reset = 1'b1;
    cfg_acc_len = '0; cfg_act_mode = '0; cfg_lrelu_shift = '0; psum_bypass_i = 1'b0;
    bus.in_valid = 1'b0; bus.psum_in = '0; bus.out_ready = 1'b0;
    test_reset();
    test_relu_group();
    test_saturate();
    test_lrelu_abs();
    test_backpressure();
    test_bypass();
    test_reset_mid();
    test_random_groups();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
